// File: rtl/image_mem_arbiter_pkg.sv
// Shared definitions for the image RAM arbiter: default RAM geometry,
// starvation limit, arbitration FSM states and read-ownership tags.
package image_mem_arbiter_pkg;

  localparam int RAM_WIDTH_DEF     = 24;
  localparam int RAM_ADDR_BITS_DEF = 10;
  localparam int MAX_WAIT_DEF      = 8;

  typedef enum logic {
    PRIO0  = 1'b0,
    FORCE1 = 1'b1
  } arb_state_t;

  localparam logic TAG_P0 = 1'b0;
  localparam logic TAG_P1 = 1'b1;

endpackage

// File: rtl/image_mem_arbiter_if.sv
// Requester-side bus of the image RAM arbiter: display reader (port 0)
// and processing engine (port 1). Requesters use the master modport,
// the arbiter uses the slave modport.
interface image_mem_arbiter_if
  import image_mem_arbiter_pkg::*;
#(
  parameter int RAM_WIDTH     = RAM_WIDTH_DEF,
  parameter int RAM_ADDR_BITS = RAM_ADDR_BITS_DEF
);

  logic                     p0_req;
  logic [RAM_ADDR_BITS-1:0] p0_addr;
  logic                     p0_gnt;
  logic                     p0_rvalid;
  logic [RAM_WIDTH-1:0]     p0_rdata;

  logic                     p1_req;
  logic                     p1_we;
  logic [RAM_ADDR_BITS-1:0] p1_addr;
  logic [RAM_WIDTH-1:0]     p1_wdata;
  logic                     p1_gnt;
  logic                     p1_rvalid;
  logic [RAM_WIDTH-1:0]     p1_rdata;

  modport master (
    output p0_req, p0_addr, p1_req, p1_we, p1_addr, p1_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata, p1_gnt, p1_rvalid, p1_rdata
  );

  modport slave (
    input  p0_req, p0_addr, p1_req, p1_we, p1_addr, p1_wdata,
    output p0_gnt, p0_rvalid, p0_rdata, p1_gnt, p1_rvalid, p1_rdata
  );

endinterface

// File: rtl/image_mem_arbiter_starve_counter.sv
// Saturating wait counter for port 1 of the image RAM arbiter. Only
// compiled when STARVE_GUARD_EN is defined; hit flags the cycle in which
// the current wait makes the count reach the limit.
`ifdef STARVE_GUARD_EN
module image_mem_arbiter_starve_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  input  logic [WIDTH-1:0] limit,
  output logic             hit
);

  logic [WIDTH-1:0] count_q;

  // Count waiting cycles up to the limit; a clear takes precedence
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count_q <= '0;
    end else if (inc && (count_q < limit)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign hit = inc && !clr && (count_q >= (limit - 1'b1));

endmodule
`endif

// File: rtl/image_mem_arbiter.sv
// Image RAM arbiter: shares one single-port RAM (sync write, async read)
// between the display reader (port 0, read-only, high priority) and the
// processing engine (port 1, read/write). Grants are combinational, the
// winning access is registered onto the RAM bus, and read data returns
// two cycles after the grant with a one-cycle valid strobe.
// Optional feature: define STARVE_GUARD_EN to bound port 1 waiting to
// MAX_WAIT cycles; otherwise port 0 has strict priority.
module image_mem_arbiter
  import image_mem_arbiter_pkg::*;
#(
  parameter int RAM_WIDTH     = RAM_WIDTH_DEF,
  parameter int RAM_ADDR_BITS = RAM_ADDR_BITS_DEF,
  parameter int MAX_WAIT      = MAX_WAIT_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  image_mem_arbiter_if.slave       bus,
  output logic                     mem_we,
  output logic [RAM_ADDR_BITS-1:0] mem_addr,
  output logic [RAM_WIDTH-1:0]     mem_di,
  input  logic [RAM_WIDTH-1:0]     mem_do
);

  arb_state_t state_q, next_state;
  logic       p0_win, p1_win;
  logic       rd_pend_q;
  logic       rd_tag_q;

`ifdef STARVE_GUARD_EN
  localparam int WAIT_BITS = $clog2(MAX_WAIT + 1);
  logic starve_hit;

  image_mem_arbiter_starve_counter #(
    .WIDTH (WAIT_BITS)
  ) u_starve_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (bus.p1_req && !p1_win),
    .clr   (p1_win),
    .limit (WAIT_BITS'(MAX_WAIT)),
    .hit   (starve_hit)
  );
`endif

  // Pick at most one winner: port 1 when alone or forced, else port 0
  always_comb begin
    p0_win = 1'b0;
    p1_win = 1'b0;
    if (!reset) begin
      p1_win = bus.p1_req && (!bus.p0_req || (state_q == FORCE1));
      p0_win = bus.p0_req && !p1_win;
    end
  end

  assign bus.p0_gnt = p0_win;
  assign bus.p1_gnt = p1_win;

  // Arbitration state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PRIO0;
    end else begin
      state_q <= next_state;
    end
  end

  // Escalate to FORCE1 once port 1 has waited long enough, return once served
  always_comb begin
    next_state = state_q;
`ifdef STARVE_GUARD_EN
    case (state_q)
      PRIO0:   if (starve_hit) next_state = FORCE1;
      FORCE1:  if (p1_win)     next_state = PRIO0;
      default: next_state = PRIO0;
    endcase
`else
    next_state = PRIO0;
`endif
  end

  // Register the accepted access onto the RAM bus; address/data hold when idle
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_di    <= '0;
      rd_pend_q <= 1'b0;
      rd_tag_q  <= TAG_P0;
    end else begin
      mem_we    <= p1_win && bus.p1_we;
      rd_pend_q <= p0_win || (p1_win && !bus.p1_we);
      if (p0_win) begin
        mem_addr <= bus.p0_addr;
        rd_tag_q <= TAG_P0;
      end else if (p1_win) begin
        mem_addr <= bus.p1_addr;
        rd_tag_q <= TAG_P1;
        if (bus.p1_we) begin
          mem_di <= bus.p1_wdata;
        end
      end
    end
  end

  // Capture RAM read data for the port that owns the access on the bus
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.p0_rvalid <= 1'b0;
      bus.p1_rvalid <= 1'b0;
      bus.p0_rdata  <= '0;
      bus.p1_rdata  <= '0;
    end else begin
      bus.p0_rvalid <= rd_pend_q && (rd_tag_q == TAG_P0);
      bus.p1_rvalid <= rd_pend_q && (rd_tag_q == TAG_P1);
      if (rd_pend_q && (rd_tag_q == TAG_P0)) begin
        bus.p0_rdata <= mem_do;
      end
      if (rd_pend_q && (rd_tag_q == TAG_P1)) begin
        bus.p1_rdata <= mem_do;
      end
    end
  end

endmodule

// File: tb/tb_image_mem_arbiter.sv
// Testbench for image_mem_arbiter: behavioural RAM on the memory bus,
// directed scenarios plus a randomized run checked against a reference
// model of the arbitration and read-latency rules.
`timescale 1ns/1ps
module tb_image_mem_arbiter;

  localparam int W     = 24;
  localparam int AB    = 10;
  localparam int MW    = 8;
  localparam int DEPTH = 1 << AB;

  typedef struct {
    int          due;
    logic [W-1:0] data;
  } rd_exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          mem_we;
  logic [AB-1:0] mem_addr;
  logic [W-1:0]  mem_di;
  logic [W-1:0]  mem_do;

  logic [W-1:0]  ram [DEPTH];
  logic          load_en;
  logic [AB-1:0] load_addr;
  logic [W-1:0]  load_data;

  logic [W-1:0]  ref_mem [DEPTH];
  rd_exp_t       q0[$];
  rd_exp_t       q1[$];
  bit            bus_chk_m;
  bit            bus_we_m;
  logic [AB-1:0] bus_addr_m;
  logic [W-1:0]  bus_di_m;
`ifdef STARVE_GUARD_EN
  int            w_m;
  bit            force_m;
`endif

  int cyc;
  int vectors;
  int miscompares;

  image_mem_arbiter_if #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB)) bus ();

  image_mem_arbiter #(
    .RAM_WIDTH     (W),
    .RAM_ADDR_BITS (AB),
    .MAX_WAIT      (MW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_di   (mem_di),
    .mem_do   (mem_do)
  );

  always #5 clk = ~clk;

  // Single-port RAM: synchronous write, asynchronous read, plus a bench load port
  always @(posedge clk) begin
    if (load_en) ram[load_addr] <= load_data;
    else if (mem_we) ram[mem_addr] <= mem_di;
  end

  assign mem_do = ram[mem_addr];

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [AB-1:0] rand_addr();
    if ($urandom_range(0, 4) == 0) return 10'h3FF;
    return AB'($urandom_range(0, 16));
  endfunction

  // Reference model: one arbitration step from the current requests.
  function automatic void model_step(output bit e0, output bit e1);
    bit r0;
    bit r1;
    r0 = bus.p0_req;
    r1 = bus.p1_req;
`ifdef STARVE_GUARD_EN
    e1 = r1 && (!r0 || force_m);
`else
    e1 = r1 && !r0;
`endif
    e0 = r0 && !e1;
`ifdef STARVE_GUARD_EN
    if (e1) begin
      w_m = 0;
      force_m = 1'b0;
    end else if (r1) begin
      w_m++;
      if (w_m >= MW) force_m = 1'b1;
    end
`endif
    bus_chk_m = e0 || e1;
    bus_we_m  = e1 && bus.p1_we;
    if (e0) begin
      bus_addr_m = bus.p0_addr;
      q0.push_back('{cyc + 2, ref_mem[bus.p0_addr]});
    end else if (e1) begin
      bus_addr_m = bus.p1_addr;
      if (bus.p1_we) begin
        ref_mem[bus.p1_addr] = bus.p1_wdata;
        bus_di_m = bus.p1_wdata;
      end else begin
        q1.push_back('{cyc + 2, ref_mem[bus.p1_addr]});
      end
    end
  endfunction

  task automatic settle();
    bus.p0_req = 1'b0;
    bus.p1_req = 1'b0;
    repeat (3) next_cycle();
    q0.delete();
    q1.delete();
    bus_chk_m = 1'b0;
    bus_we_m  = 1'b0;
  endtask

  task automatic preload();
    for (int i = 0; i < 18; i++) begin
      load_en   = 1'b1;
      load_addr = (i == 17) ? 10'h3FF : AB'(i);
      load_data = (i == 5) ? 24'hABCDEF : W'($urandom);
      ref_mem[load_addr] = load_data;
      next_cycle();
    end
    load_en = 1'b0;
  endtask

  task automatic test_reset();
    bus.p0_req = 1'b1; bus.p0_addr = 10'h001;
    bus.p1_req = 1'b1; bus.p1_we = 1'b1; bus.p1_addr = 10'h002; bus.p1_wdata = 24'h777777;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++; if (bus.p0_gnt !== 1'b0) begin miscompares++; $display("[TB] FAIL reset p0_gnt: got %b want 0", bus.p0_gnt); end
      vectors++; if (bus.p1_gnt !== 1'b0) begin miscompares++; $display("[TB] FAIL reset p1_gnt: got %b want 0", bus.p1_gnt); end
      vectors++; if (bus.p0_rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset p0_rvalid: got %b want 0", bus.p0_rvalid); end
      vectors++; if (bus.p1_rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset p1_rvalid: got %b want 0", bus.p1_rvalid); end
      vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL reset mem_we: got %b want 0", mem_we); end
      vectors++; if (mem_addr !== 10'h000) begin miscompares++; $display("[TB] FAIL reset mem_addr: got %h want 000", mem_addr); end
      next_cycle();
    end
    bus.p0_req = 1'b0;
    bus.p1_req = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    vectors++; if (bus.p0_rdata !== 24'h0) begin miscompares++; $display("[TB] FAIL reset p0_rdata: got %h want 000000", bus.p0_rdata); end
    next_cycle();
  endtask

  task automatic test_lone_read();
    bus.p0_req = 1'b1; bus.p0_addr = 10'h005;
    @(negedge clk);
    vectors++; if (bus.p0_gnt !== 1'b1) begin miscompares++; $display("[TB] FAIL lone p0_gnt: got %b want 1", bus.p0_gnt); end
    vectors++; if (bus.p1_gnt !== 1'b0) begin miscompares++; $display("[TB] FAIL lone p1_gnt: got %b want 0", bus.p1_gnt); end
    next_cycle();
    bus.p0_req = 1'b0;
    @(negedge clk);
    vectors++; if (mem_addr !== 10'h005) begin miscompares++; $display("[TB] FAIL lone mem_addr: got %h want 005", mem_addr); end
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL lone mem_we: got %b want 0", mem_we); end
    vectors++; if (bus.p0_rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL lone early rvalid: got %b want 0", bus.p0_rvalid); end
    next_cycle();
    @(negedge clk);
    vectors++; if (bus.p0_rvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL lone p0_rvalid: got %b want 1", bus.p0_rvalid); end
    vectors++; if (bus.p0_rdata !== 24'hABCDEF) begin miscompares++; $display("[TB] FAIL lone p0_rdata: got %h want abcdef", bus.p0_rdata); end
    vectors++; if (bus.p1_rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL lone p1_rvalid: got %b want 0", bus.p1_rvalid); end
    next_cycle();
    @(negedge clk);
    vectors++; if (bus.p0_rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL lone rvalid pulse: got %b want 0", bus.p0_rvalid); end
    next_cycle();
  endtask

  task automatic test_write_read();
    bus.p1_req = 1'b1; bus.p1_we = 1'b1; bus.p1_addr = 10'h3FF; bus.p1_wdata = 24'h123456;
    @(negedge clk);
    vectors++; if (bus.p1_gnt !== 1'b1) begin miscompares++; $display("[TB] FAIL wr p1_gnt: got %b want 1", bus.p1_gnt); end
    next_cycle();
    bus.p1_we = 1'b0; bus.p1_wdata = 24'h0;
    @(negedge clk);
    vectors++; if (mem_we !== 1'b1) begin miscompares++; $display("[TB] FAIL wr mem_we: got %b want 1", mem_we); end
    vectors++; if (mem_addr !== 10'h3FF) begin miscompares++; $display("[TB] FAIL wr mem_addr: got %h want 3ff", mem_addr); end
    vectors++; if (mem_di !== 24'h123456) begin miscompares++; $display("[TB] FAIL wr mem_di: got %h want 123456", mem_di); end
    vectors++; if (bus.p1_gnt !== 1'b1) begin miscompares++; $display("[TB] FAIL rd p1_gnt: got %b want 1", bus.p1_gnt); end
    next_cycle();
    bus.p1_req = 1'b0;
    @(negedge clk);
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL wr mem_we pulse: got %b want 0", mem_we); end
    vectors++; if (bus.p1_rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL wr p1_rvalid: got %b want 0", bus.p1_rvalid); end
    next_cycle();
    @(negedge clk);
    vectors++; if (bus.p1_rvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL raw p1_rvalid: got %b want 1", bus.p1_rvalid); end
    vectors++; if (bus.p1_rdata !== 24'h123456) begin miscompares++; $display("[TB] FAIL raw p1_rdata: got %h want 123456", bus.p1_rdata); end
    ref_mem[10'h3FF] = 24'h123456;
    next_cycle();
  endtask

  task automatic test_conflict();
    bit e0;
    bit e1;
    bus.p0_req = 1'b1; bus.p0_addr = 10'h003;
    bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 10'h004;
    for (int i = 0; i < 2 * (MW + 1); i++) begin
      @(negedge clk);
      model_step(e0, e1);
      vectors++; if (bus.p0_gnt !== e0) begin miscompares++; $display("[TB] FAIL conflict p0_gnt cyc %0d: got %b want %b", i, bus.p0_gnt, e0); end
      vectors++; if (bus.p1_gnt !== e1) begin miscompares++; $display("[TB] FAIL conflict p1_gnt cyc %0d: got %b want %b", i, bus.p1_gnt, e1); end
      next_cycle();
    end
    settle();
  endtask

  task automatic test_random(input int n);
    bit  e0 = 1'b0;
    bit  e1 = 1'b0;
    bit  x0;
    bit  x1;
    for (int i = 0; i < n; i++) begin
      if (!bus.p0_req || e0) begin
        bus.p0_req  = ($urandom_range(0, 2) != 0);
        bus.p0_addr = rand_addr();
      end
      if (!bus.p1_req || e1) begin
        bus.p1_req   = 1'($urandom_range(0, 1));
        bus.p1_we    = 1'($urandom_range(0, 1));
        bus.p1_addr  = rand_addr();
        bus.p1_wdata = W'($urandom);
      end
      @(negedge clk);
      vectors++; if (mem_we !== bus_we_m) begin miscompares++; $display("[TB] FAIL rand mem_we cyc %0d: got %b want %b", cyc, mem_we, bus_we_m); end
      if (bus_chk_m) begin
        vectors++; if (mem_addr !== bus_addr_m) begin miscompares++; $display("[TB] FAIL rand mem_addr cyc %0d: got %h want %h", cyc, mem_addr, bus_addr_m); end
      end
      if (bus_we_m) begin
        vectors++; if (mem_di !== bus_di_m) begin miscompares++; $display("[TB] FAIL rand mem_di cyc %0d: got %h want %h", cyc, mem_di, bus_di_m); end
      end
      x0 = (q0.size() > 0) && (q0[0].due == cyc);
      x1 = (q1.size() > 0) && (q1[0].due == cyc);
      vectors++; if (bus.p0_rvalid !== x0) begin miscompares++; $display("[TB] FAIL rand p0_rvalid cyc %0d: got %b want %b", cyc, bus.p0_rvalid, x0); end
      vectors++; if (bus.p1_rvalid !== x1) begin miscompares++; $display("[TB] FAIL rand p1_rvalid cyc %0d: got %b want %b", cyc, bus.p1_rvalid, x1); end
      if (x0) begin
        vectors++; if (bus.p0_rdata !== q0[0].data) begin miscompares++; $display("[TB] FAIL rand p0_rdata cyc %0d: got %h want %h", cyc, bus.p0_rdata, q0[0].data); end
        void'(q0.pop_front());
      end
      if (x1) begin
        vectors++; if (bus.p1_rdata !== q1[0].data) begin miscompares++; $display("[TB] FAIL rand p1_rdata cyc %0d: got %h want %h", cyc, bus.p1_rdata, q1[0].data); end
        void'(q1.pop_front());
      end
      model_step(e0, e1);
      vectors++; if (bus.p0_gnt !== e0) begin miscompares++; $display("[TB] FAIL rand p0_gnt cyc %0d: got %b want %b", cyc, bus.p0_gnt, e0); end
      vectors++; if (bus.p1_gnt !== e1) begin miscompares++; $display("[TB] FAIL rand p1_gnt cyc %0d: got %b want %b", cyc, bus.p1_gnt, e1); end
      next_cycle();
    end
    settle();
  endtask

  task automatic test_reset_mid_access();
    // read accepted, then reset while it is on the RAM bus: dropped
    bus.p0_req = 1'b1; bus.p0_addr = 10'h007;
    @(negedge clk);
    vectors++; if (bus.p0_gnt !== 1'b1) begin miscompares++; $display("[TB] FAIL midrd p0_gnt: got %b want 1", bus.p0_gnt); end
    next_cycle();
    bus.p0_req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    vectors++; if (bus.p0_rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL midrd early rvalid: got %b want 0", bus.p0_rvalid); end
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    vectors++; if (bus.p0_rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL midrd dropped rvalid: got %b want 0", bus.p0_rvalid); end
    next_cycle();
    @(negedge clk);
    vectors++; if (bus.p0_rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL midrd late rvalid: got %b want 0", bus.p0_rvalid); end
    next_cycle();

    // write accepted, then reset while it is on the RAM bus: commits
    bus.p1_req = 1'b1; bus.p1_we = 1'b1; bus.p1_addr = 10'h010; bus.p1_wdata = 24'h5A5A01;
    @(negedge clk);
    vectors++; if (bus.p1_gnt !== 1'b1) begin miscompares++; $display("[TB] FAIL midwr p1_gnt: got %b want 1", bus.p1_gnt); end
    next_cycle();
    bus.p1_req = 1'b0;
    bus.p0_req = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    vectors++; if (bus.p0_gnt !== 1'b0) begin miscompares++; $display("[TB] FAIL midwr p0_gnt in reset: got %b want 0", bus.p0_gnt); end
    vectors++; if (mem_we !== 1'b1) begin miscompares++; $display("[TB] FAIL midwr mem_we on bus: got %b want 1", mem_we); end
    next_cycle();
    reset = 1'b0;
    bus.p0_req = 1'b0;
    @(negedge clk);
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL midwr mem_we after reset: got %b want 0", mem_we); end
    vectors++; if (ram[10'h010] !== 24'h5A5A01) begin miscompares++; $display("[TB] FAIL midwr ram[010]: got %h want 5a5a01", ram[10'h010]); end
    vectors++; if (bus.p0_rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL midwr p0_rvalid: got %b want 0", bus.p0_rvalid); end
    vectors++; if (bus.p1_rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL midwr p1_rvalid: got %b want 0", bus.p1_rvalid); end
    next_cycle();
    @(negedge clk);
    vectors++; if (bus.p1_rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL midwr late p1_rvalid: got %b want 0", bus.p1_rvalid); end
    next_cycle();
  endtask

  initial begin
    cyc         = 0;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    load_en     = 1'b0;
    load_addr   = '0;
    load_data   = '0;
    bus_chk_m   = 1'b0;
    bus_we_m    = 1'b0;
    bus_addr_m  = '0;
    bus_di_m    = '0;
`ifdef STARVE_GUARD_EN
    w_m         = 0;
    force_m     = 1'b0;
`endif
    bus.p0_req   = 1'b0;
    bus.p0_addr  = '0;
    bus.p1_req   = 1'b0;
    bus.p1_we    = 1'b0;
    bus.p1_addr  = '0;
    bus.p1_wdata = '0;

    preload();
    test_reset();
    test_lone_read();
    test_write_read();
    test_conflict();
    test_random(400);
    test_reset_mid_access();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
